seq_pattern_tx: RTL
===================

// Module: seq_pattern_tx
// PURPOSE
//  Bit-serial frame transmitter; the transmit end of the serial sync-pattern link
//  whose receive end is the Mealy sequence detector.
//  Per frame: fixed sync preamble, then DATA_W payload bits MSB first, then one guard (stop) bit of 0.
//  Used as the link driver and as the stimulus source for detector benches.
// PARAMETERS
//  DATA_W        8        payload width in bits, >=1
//  PRE_W         4        preamble width in bits, >=1
//  PREAMBLE      4'b1001  sync pattern, sent MSB first
//  CLKS_PER_BIT  4        clk cycles each serial bit is held, >=1 (1 must work)
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       reset, asynchronous, active-high
//  tx_data     in   DATA_W  payload word, sampled on accept
//  tx_valid    in   1       payload offered
//  tx_ready    out  1       block can accept a frame
//  outp        out  1       serial line; idle level 0
//  busy        out  1       frame in progress
//  frame_done  out  1       one-cycle pulse after the stop bit completes
// BEHAVIOUR
//  Reset: all outputs registered; outp=0, busy=0, frame_done=0, tx_ready=1, state=IDLE.
//  Reset is async: asserting rst mid-frame forces outp=0 at once and aborts the frame.
//  Handshake:
//   - Accept = tx_valid && tx_ready at a rising clk edge.
//   - tx_ready=1 only in IDLE; tx_valid while busy is ignored (no queueing).
//   - tx_data is captured into a shift register on accept; later changes have no effect.
//  Latency: on the accept edge the state becomes PRE, outp <= PREAMBLE[PRE_W-1], busy <= 1, tx_ready <= 0.
//  Bit timing: every line bit is held exactly CLKS_PER_BIT cycles.
//   - Timer counts 0..CLKS_PER_BIT-1; the next bit is driven on the edge where the timer wraps.
//  FSM:
//   - IDLE -> PRE on accept.
//   - PRE (PRE_W bits) -> DATA.
//   - DATA (DATA_W bits, MSB first) -> PAR if PARITY_EN, else STOP.
//   - PAR (1 bit) -> STOP.
//   - STOP (1 bit, outp=0) -> IDLE.
//  Leaving STOP:
//   - Edge where the STOP timer wraps: state=IDLE, busy<=0, tx_ready<=1, frame_done<=1.
//   - Next edge: frame_done<=0.
//  Back-to-back: earliest next accept is the edge after tx_ready returns high.
//   - This leaves >=1 idle cycle of 0 plus the stop bit between frames.
//  Counters: the bit index has width $clog2(max(PRE_W,DATA_W)+1).
//   - No wrap beyond a segment length; the index clears on each segment change.
//  outp is glitch-free, driven straight from a flop.
// CONFIGURATION
//  SEQ_TX_PARITY_EN defined:
//   - A PAR bit = even parity (XOR of the captured DATA_W bits) is sent between DATA and STOP.
//   - Frame length = PRE_W+DATA_W+2 bits.
//  Not defined:
//   - No PAR state or logic.
//   - Frame length = PRE_W+DATA_W+1 bits.
// TESTING (defaults: DATA_W=8, PRE_W=4, PREAMBLE=1001, CLKS_PER_BIT=4)
//  1 Reset: rst=1 mid-frame -> outp=0, busy=0 immediately.
//    After release: tx_ready=1, frame_done=0, no line activity.
//  2 Accept 8'hA5, parity off -> outp = 1,0,0,1,1,0,1,0,0,1,0,1,0, each held 4 cycles (52 cycles).
//    frame_done pulses one cycle at accept edge +52; tx_ready=1 from then.
//  3 SEQ_TX_PARITY_EN, accept 8'h07 -> payload 00000111 then parity bit 1, then stop 0.
//    Frame is 56 cycles.
//  4 Hold tx_valid=1 continuously with data changing every cycle:
//    - Each frame carries the word present at its accept edge.
//    - Accepts occur exactly 53 cycles apart.
//    - tx_data changes while busy are not transmitted.
//  5 CLKS_PER_BIT=1, accept 8'hFF -> 13 consecutive single-cycle bits 1,0,0,1,1x8,0.
//    frame_done at accept edge +13.
//  6 Loopback into the sequence detector with payload 8'h00:
//    the detector flags the preamble exactly once per frame.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial frame transmitter (preamble, payload MSB first, stop 0); define SEQ_TX_PARITY_EN to add an even-parity bit before stop
module seq_pattern_tx #(
   parameter int               DATA_W       = 8,
   parameter int               PRE_W        = 4,
   parameter logic [PRE_W-1:0] PREAMBLE     = 4'b1001,
   parameter int               CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              outp,
   output logic              busy,
   output logic              frame_done
);
   localparam int MX = PRE_W > DATA_W ? PRE_W : DATA_W;
   localparam int IW = $clog2(MX + 1);
   localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
   typedef enum logic [2:0] {
      IDLE,
      PRE,
      DATA,
`ifdef SEQ_TX_PARITY_EN
      PAR,
`endif
      STOP
   } state_t;
   state_t            state;
   logic [TW-1:0]     tmr;
   logic [IW-1:0]     idx;
   logic [PRE_W-1:0]  pre, pre_nx;
   logic [DATA_W-1:0] sh, sh_nx;
   logic              wrap;
`ifdef SEQ_TX_PARITY_EN
   logic              par;
`endif
   assign pre_nx = pre << 1;
   assign sh_nx  = sh << 1;
   assign wrap   = tmr == TW'(CLKS_PER_BIT - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         tmr        <= '0;
         idx        <= '0;
         pre        <= PREAMBLE;
         sh         <= '0;
`ifdef SEQ_TX_PARITY_EN
         par        <= 1'b0;
`endif
         outp       <= 1'b0;
         busy       <= 1'b0;
         tx_ready   <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (state == IDLE) begin
            if (tx_valid && tx_ready) begin
               state    <= PRE;
               tmr      <= '0;
               idx      <= '0;
               pre      <= PREAMBLE;
               sh       <= tx_data;
`ifdef SEQ_TX_PARITY_EN
               par      <= ^tx_data;
`endif
               outp     <= PREAMBLE[PRE_W-1];
               busy     <= 1'b1;
               tx_ready <= 1'b0;
            end
         end else if (!wrap) begin
            tmr <= tmr + 1'b1;
         end else begin
            tmr <= '0;
            idx <= idx + 1'b1;
            case (state)
               PRE:
                  if (idx == IW'(PRE_W - 1)) begin
                     state <= DATA;
                     idx   <= '0;
                     outp  <= sh[DATA_W-1];
                  end else begin
                     pre  <= pre_nx;
                     outp <= pre_nx[PRE_W-1];
                  end
               DATA:
                  if (idx == IW'(DATA_W - 1)) begin
                     idx   <= '0;
`ifdef SEQ_TX_PARITY_EN
                     state <= PAR;
                     outp  <= par;
`else
                     state <= STOP;
                     outp  <= 1'b0;
`endif
                  end else begin
                     sh   <= sh_nx;
                     outp <= sh_nx[DATA_W-1];
                  end
`ifdef SEQ_TX_PARITY_EN
               PAR: begin
                  state <= STOP;
                  idx   <= '0;
                  outp  <= 1'b0;
               end
`endif
               default: begin
                  state      <= IDLE;
                  idx        <= '0;
                  outp       <= 1'b0;
                  busy       <= 1'b0;
                  tx_ready   <= 1'b1;
                  frame_done <= 1'b1;
               end
            endcase
         end
      end
endmodule
